// File: rtl/regbank_dump_reader.sv
// regbank_dump_reader: on request, freezes the pipeline, walks every register
// address in order and streams each word MSB-first, one byte at a time, over a
// valid/ready byte interface toward the debug UART transmitter.
// Optional build macro: REGDUMP_HEADER_EN adds a leading 8'hA5 marker byte.
module regbank_dump_reader #(
    parameter int unsigned addr_bits = 5,
    parameter int unsigned word_wide = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic [addr_bits-1:0] dumpAddr,
    input  logic [word_wide-1:0] dumpData,
    output logic                 freeze,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           txData,
    output logic                 txValid,
    input  logic                 txReady
);

    localparam int unsigned bytesPerWord = word_wide / 8;
    localparam int unsigned byteBits     = (bytesPerWord > 1) ? $clog2(bytesPerWord) : 1;
    localparam logic [byteBits-1:0]  lastByte = byteBits'(bytesPerWord - 1);
    localparam logic [addr_bits-1:0] lastReg  = {addr_bits{1'b1}};
    localparam logic [7:0]           headerByte = 8'hA5;

    localparam logic [2:0] sIdle   = 3'd0;
    localparam logic [2:0] sLoad   = 3'd1;
    localparam logic [2:0] sSend   = 3'd2;
    localparam logic [2:0] sDone   = 3'd3;
`ifdef REGDUMP_HEADER_EN
    localparam logic [2:0] sHeader = 3'd4;
`endif

    logic [2:0]           state,      stateNext;
    logic [addr_bits-1:0] regIdx,     regIdxNext;
    logic [byteBits-1:0]  byteIdx,    byteIdxNext;
    logic [word_wide-1:0] shift,      shiftNext;
    logic [word_wide-1:0] shiftShifted;
    logic [7:0]           txDataNext;
    logic                 txValidNext;
    logic                 busyNext;
    logic                 freezeNext;
    logic                 doneNext;

    // The read address is the register index flop itself.
    assign dumpAddr = regIdx;

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= sIdle;
            regIdx  <= '0;
            byteIdx <= '0;
            shift   <= '0;
            txData  <= '0;
            txValid <= 1'b0;
            busy    <= 1'b0;
            freeze  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= stateNext;
            regIdx  <= regIdxNext;
            byteIdx <= byteIdxNext;
            shift   <= shiftNext;
            txData  <= txDataNext;
            txValid <= txValidNext;
            busy    <= busyNext;
            freeze  <= freezeNext;
            done    <= doneNext;
        end
    end

    // Next-state and next-output decode; outputs follow the state being entered.
    always_comb begin
        stateNext    = state;
        regIdxNext   = regIdx;
        byteIdxNext  = byteIdx;
        shiftNext    = shift;
        txDataNext   = txData;
        txValidNext  = txValid;
        shiftShifted = shift << 8;

        case (state)
            sIdle: begin
                regIdxNext  = '0;
                txValidNext = 1'b0;
                txDataNext  = 8'h00;
                if (start) begin
`ifdef REGDUMP_HEADER_EN
                    stateNext   = sHeader;
                    txValidNext = 1'b1;
                    txDataNext  = headerByte;
`else
                    stateNext   = sLoad;
`endif
                end
            end
`ifdef REGDUMP_HEADER_EN
            sHeader: begin
                if (txReady) begin
                    stateNext   = sLoad;
                    txValidNext = 1'b0;
                    txDataNext  = 8'h00;
                end
            end
`endif
            sLoad: begin
                // Bank read is combinational: capture the word in this cycle.
                shiftNext   = dumpData;
                byteIdxNext = '0;
                txDataNext  = dumpData[word_wide-1 -: 8];
                txValidNext = 1'b1;
                stateNext   = sSend;
            end
            sSend: begin
                if (txReady) begin
                    if (byteIdx != lastByte) begin
                        shiftNext   = shiftShifted;
                        byteIdxNext = byteIdx + byteBits'(1);
                        txDataNext  = shiftShifted[word_wide-1 -: 8];
                    end else begin
                        txValidNext = 1'b0;
                        txDataNext  = 8'h00;
                        if (regIdx != lastReg) begin
                            regIdxNext = regIdx + addr_bits'(1);
                            stateNext  = sLoad;
                        end else begin
                            stateNext  = sDone;
                        end
                    end
                end
            end
            sDone: begin
                stateNext = sIdle;
            end
            default: begin
                stateNext   = sIdle;
                txValidNext = 1'b0;
                txDataNext  = 8'h00;
            end
        endcase

        busyNext   = (stateNext != sIdle);
        freezeNext = (stateNext != sIdle);
        doneNext   = (stateNext == sDone);
    end

endmodule

// File: tb/tb_regbank_dump_reader.sv
// Bench for regbank_dump_reader: a bank array feeds the read port, a queue of
// expected bytes is built from the bank contents, and a per-cycle monitor
// checks the byte stream, handshake stability and timing counts.
module tb_regbank_dump_reader;

    localparam int unsigned AW   = 5;
    localparam int unsigned WW   = 32;
    localparam int unsigned BPW  = WW / 8;
    localparam int unsigned NREG = 1 << AW;
`ifdef REGDUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          txReady = 1'b1;
    logic [AW-1:0] dumpAddr;
    logic [WW-1:0] dumpData;
    logic          freeze;
    logic          busy;
    logic          done;
    logic [7:0]    txData;
    logic          txValid;

    logic [WW-1:0] bank [NREG];
    assign dumpData = bank[dumpAddr];

    regbank_dump_reader #(.addr_bits(AW), .word_wide(WW)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dumpAddr (dumpAddr),
        .dumpData (dumpData),
        .freeze   (freeze),
        .busy     (busy),
        .done     (done),
        .txData   (txData),
        .txValid  (txValid),
        .txReady  (txReady)
    );

    initial forever #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc = 0, byteCount = 0, stallCount = 0, busyCount = 0, freezeCount = 0;
    int doneCount = 0, doneCyc = 0;
    int lastLatency = 0, lastStalls = 0;
    bit readyRandom = 1'b0;
    logic [7:0] expQ [$];
    logic [7:0] got  [$];

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Transmitter-side ready: always high, or random with ~1/3 stalls.
    initial forever begin
        @(posedge clock);
        #1;
        txReady = readyRandom ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Per-cycle monitor: byte stream vs model queue, stall stability, counters.
    initial begin : monitor
        bit         prevStall;
        logic [7:0] prevData;
        prevStall = 1'b0;
        prevData  = 8'h00;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                prevStall = 1'b0;
            end else begin
                if (txValid) chk("valid_without_busy", busy, 1);
                if (done)    chk("done_without_busy", busy, 1);
                if (prevStall) begin
                    chk("stall_valid_dropped", txValid, 1);
                    chk("stall_data_changed", txData, prevData);
                end
                if (busy)   busyCount++;
                if (freeze) freezeCount++;
                if (done) begin
                    doneCount++;
                    doneCyc = cyc;
                end
                if (txValid && txReady) begin
                    got.push_back(txData);
                    byteCount++;
                    if (expQ.size() == 0) chk("unexpected_byte_count", byteCount, 0);
                    else chk("byte", txData, expQ.pop_front());
                end
                if (txValid && !txReady) stallCount++;
                prevStall = txValid && !txReady;
                prevData  = txData;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic preloadPattern();
        for (int i = 0; i < int'(NREG); i++) bank[i] = WW'(32'h01020300 + i);
    endtask

    task automatic pushDump();
        logic [WW-1:0] w;
        if (HDR != 0) expQ.push_back(8'hA5);
        for (int r = 0; r < int'(NREG); r++) begin
            w = bank[r];
            for (int b = 0; b < int'(BPW); b++)
                expQ.push_back(8'(w >> (8 * (int'(BPW) - 1 - b))));
        end
    endtask

    task automatic fireStart(output int t0);
        @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic waitDone(input int prev, input int bound);
        for (int i = 0; i < bound && doneCount == prev; i++) tick();
        if (doneCount == prev) chk("done_timeout", doneCount, prev + 1);
    endtask

    task automatic fullDump(input string nm, input bit pokeStart);
        int t0, s0, b0, bz0, fz0, d0;
        pushDump();
        s0 = stallCount; b0 = byteCount; bz0 = busyCount; fz0 = freezeCount; d0 = doneCount;
        fireStart(t0);
        if (pokeStart) begin
            for (int k = 0; k < 4; k++) begin
                repeat (20) @(posedge clock);
                #1;
                start = 1'b1;
                @(posedge clock);
                #1;
                start = 1'b0;
            end
        end
        waitDone(d0, 4000);
        tick();
        tick();
        lastStalls  = stallCount - s0;
        lastLatency = doneCyc - t0;
        chk({nm, "_done_cycle"},    lastLatency, 161 + HDR + lastStalls);
        chk({nm, "_busy_cycles"},   busyCount - bz0, 161 + HDR + lastStalls);
        chk({nm, "_freeze_cycles"}, freezeCount - fz0, 161 + HDR + lastStalls);
        chk({nm, "_byte_total"},    byteCount - b0, 128 + HDR);
        chk({nm, "_done_pulses"},   doneCount - d0, 1);
        chk({nm, "_bytes_missing"}, expQ.size(), 0);
        chk({nm, "_idle_busy"},     busy, 0);
    endtask

    // Global time bound.
    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int b0, d0, t0, dEdge;

        // Reset values.
        tick();
        tick();
        chk("rst_dumpAddr", dumpAddr, 0);
        chk("rst_txData", txData, 0);
        chk("rst_txValid", txValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_freeze", freeze, 0);
        chk("rst_done", done, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) tick();

        // Known pattern, ready always high.
        preloadPattern();
        readyRandom = 1'b0;
        got.delete();
        fullDump("seq", 1'b0);
        chk("seq_latency_literal", lastLatency, 161 + HDR);
        chk("seq_first_byte", got[0], (HDR != 0) ? 8'hA5 : 8'h01);
        chk("seq_byte3", got[HDR + 3], 8'h00);
        chk("seq_byte7", got[HDR + 7], 8'h01);
        chk("seq_last_byte", got[HDR + 127], 8'h1F);

        // Same pattern, random stalls.
        readyRandom = 1'b1;
        got.delete();
        fullDump("stall", 1'b0);
        chk("stall_seen", (lastStalls > 0) ? 1 : 0, 1);
        chk("stall_byte3", got[HDR + 3], 8'h00);

        // Random bank contents, random stalls.
        for (int i = 0; i < int'(NREG); i++) bank[i] = WW'($urandom);
        fullDump("rand", 1'b0);

        // Reset during register 7 byte 2, then replay from register 0.
        preloadPattern();
        pushDump();
        b0 = byteCount;
        fireStart(t0);
        for (int i = 0; i < 3000 && (byteCount - b0) < 30 + HDR; i++) tick();
        chk("reset_reach", byteCount - b0, 30 + HDR);
        tick();
        chk("reset_point_addr", dumpAddr, 7);
        chk("reset_point_valid", txValid, 1);
        reset = 1'b1;
        tick();
        chk("midrst_dumpAddr", dumpAddr, 0);
        chk("midrst_txData", txData, 0);
        chk("midrst_txValid", txValid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_freeze", freeze, 0);
        chk("midrst_done", done, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        expQ.delete();
        got.delete();
        tick();
        fullDump("replay", 1'b0);
        chk("replay_first_byte", got[0], (HDR != 0) ? 8'hA5 : 8'h01);

        // Start pulses while busy are ignored.
        readyRandom = 1'b0;
        fullDump("poke", 1'b1);

        // Start held high: back-to-back dumps.
        pushDump();
        pushDump();
        d0 = doneCount;
        b0 = byteCount;
        @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock);
        #1;
        t0 = cyc;
        waitDone(d0, 4000);
        dEdge = doneCyc;
        chk("b2b_first_done", dEdge - t0, 161 + HDR);
        tick();
        chk("b2b_gap_busy", busy, 0);
        tick();
        chk("b2b_restart_busy", busy, 1);
        chk("b2b_restart_addr", dumpAddr, 0);
        @(posedge clock);
        #1;
        start = 1'b0;
        waitDone(d0 + 1, 4000);
        chk("b2b_second_done", doneCyc - dEdge, 162 + HDR);
        repeat (5) tick();
        chk("b2b_done_pulses", doneCount - d0, 2);
        chk("b2b_byte_total", byteCount - b0, 2 * (128 + HDR));
        chk("b2b_bytes_missing", expQ.size(), 0);
        chk("b2b_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
